// File: rtl/tpu_skew_feeder_if.sv
// Handshake and array-edge bundle for tpu_skew_feeder.
// Lane i of in_data/out_data occupies bits [i*BITS_AB +: BITS_AB].
interface tpu_skew_feeder_if #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DIM*BITS_AB-1:0] in_data;
    logic                   in_last;
    logic [DIM*BITS_AB-1:0] out_data;
    logic                   out_en;
    logic                   busy;
    logic                   done;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_data, out_en, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_data, out_en, busy, done
    );
endinterface

// File: rtl/tpu_skew_feeder.sv
// Diagonal-skew operand feeder for one systolic array edge; lane i lags lane 0 by i shifts.
// Optional macro TPU_FEEDER_BUBBLE_EN: an idle STREAM cycle shifts a zero vector instead of stalling.
module tpu_skew_lane #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [DEPTH-1:0][W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (shift) begin
            sr[0] <= din;
            for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

module tpu_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tpu_skew_feeder_if.slave   bus
);
    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    // Flush needs DIM-1 edges after the last accept; counter runs DIM-2 down to 0.
    localparam logic [CW-1:0] CNT_INIT = CW'((DIM > 1) ? DIM - 2 : 0);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t  state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic    ready, accept, shift, done_nxt;
    logic [DIM-1:0][BITS_AB-1:0] in_lanes, head, tail;

    assign in_lanes = bus.in_data;
    assign ready    = (state != FLUSH);
    assign accept   = bus.in_valid && ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift     = 1'b0;
        done_nxt  = 1'b0;
        head      = '0;
        unique case (state)
            IDLE, STREAM: begin
                if (accept) begin
                    shift = 1'b1;
                    head  = in_lanes;
                    if (bus.in_last) begin
                        if (DIM == 1) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = FLUSH;
                            cnt_nxt   = CNT_INIT;
                        end
                    end else begin
                        state_nxt = STREAM;
                    end
                end
`ifdef TPU_FEEDER_BUBBLE_EN
                else if (state == STREAM) begin
                    shift = 1'b1;
                end
`endif
            end
            FLUSH: begin
                shift = 1'b1;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bus.out_en <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bus.out_en <= shift;
            bus.done   <= done_nxt;
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        tpu_skew_lane #(
            .W     (BITS_AB),
            .DEPTH (i + 1)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .shift (shift),
            .din   (head[i]),
            .dout  (tail[i])
        );
    end

    assign bus.out_data = tail;
    assign bus.in_ready = ready;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_tpu_skew_feeder.sv
// Directed table-driven bench for tpu_skew_feeder (DIM=4 instance plus a DIM=1 instance).
module tb_tpu_skew_feeder;
    localparam int B = 8;
`ifdef TPU_FEEDER_BUBBLE_EN
    localparam bit BUB = 1'b1;
`else
    localparam bit BUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tpu_skew_feeder_if #(.BITS_AB(B), .DIM(4)) bus  ();
    tpu_skew_feeder_if #(.BITS_AB(B), .DIM(1)) bus1 ();

    tpu_skew_feeder #(.BITS_AB(B), .DIM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    tpu_skew_feeder #(.BITS_AB(B), .DIM(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        last;
        logic [31:0] exp_out;
        logic        exp_en;
        logic        exp_done;
        logic        exp_busy;
        logic        exp_ready;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic vec_t mk(logic v, logic [31:0] d, logic l, logic [31:0] o,
                                logic en, logic dn, logic bsy, logic rdy);
        vec_t r;
        r.vld = v; r.data = d; r.last = l; r.exp_out = o;
        r.exp_en = en; r.exp_done = dn; r.exp_busy = bsy; r.exp_ready = rdy;
        return r;
    endfunction

    task automatic step1(input logic v, input logic [7:0] d, input logic l);
        bus1.in_valid = v;
        bus1.in_data  = d;
        bus1.in_last  = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // in_last without valid is ignored in IDLE
        tbl.push_back(mk(0, 32'hFFFFFFFF, 1, 32'h00000000, 0, 0, 0, 1));
        // gap-free stream of three vectors
        tbl.push_back(mk(1, 32'h04030201, 0, 32'h00000001, 1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h08070605, 0, 32'h00000205, 1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h0C0B0A09, 1, 32'h00030609, 1, 0, 1, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 32'h04070A00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h080B0000, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h0C000000, 1, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 32'h0C000000, 0, 0, 0, 1));
        // two-cycle input gap after the first accept
        tbl.push_back(mk(1, 32'h04030201, 0, 32'h00000001, 1, 0, 1, 1));
        tbl.push_back(mk(0, 32'h0, 0, BUB ? 32'h00000200 : 32'h00000001, BUB, 0, 1, 1));
        tbl.push_back(mk(0, 32'h0, 0, BUB ? 32'h00030000 : 32'h00000001, BUB, 0, 1, 1));
        tbl.push_back(mk(1, 32'h08070605, 0, BUB ? 32'h04000005 : 32'h00000205, 1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h0C0B0A09, 1, BUB ? 32'h00000609 : 32'h00030609, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0, 0, BUB ? 32'h00070A00 : 32'h04070A00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0, 0, 32'h080B0000, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0, 0, 32'h0C000000, 1, 1, 0, 1));
        // single-vector op, flush ignores valid, next op accepted in done cycle
        tbl.push_back(mk(1, 32'h04030201, 1, 32'h00000001, 1, 0, 1, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 32'h00000200, 1, 0, 1, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 32'h00030000, 1, 0, 1, 0));
        tbl.push_back(mk(1, 32'hFFFFFFFF, 1, 32'h04000000, 1, 1, 0, 1));
        tbl.push_back(mk(1, 32'h08070605, 1, 32'h00000005, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h00000600, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h00070000, 1, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h08000000, 1, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,        0, 32'h08000000, 0, 0, 0, 1));

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_last = 1'b0;
        #3;
        check("reset out_data", bus.out_data, 32'h0);
        check("reset out_en", 32'(bus.out_en), 32'h0);
        check("reset done", 32'(bus.done), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            bus.in_valid = tbl[i].vld;
            bus.in_data  = tbl[i].data;
            bus.in_last  = tbl[i].last;
            @(posedge clk);
            #1;
            check($sformatf("row%0d out_data", i), bus.out_data, tbl[i].exp_out);
            check($sformatf("row%0d out_en", i), 32'(bus.out_en), 32'(tbl[i].exp_en));
            check($sformatf("row%0d done", i), 32'(bus.done), 32'(tbl[i].exp_done));
            check($sformatf("row%0d busy", i), 32'(bus.busy), 32'(tbl[i].exp_busy));
            check($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_ready));
        end

        // asynchronous reset in the middle of a stream
        bus.in_valid = 1'b1; bus.in_data = 32'h04030201; bus.in_last = 1'b0;
        @(posedge clk);
        #1;
        check("midrst pre out_data", bus.out_data, 32'h00000001);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_data", bus.out_data, 32'h0);
        check("midrst out_en", 32'(bus.out_en), 32'h0);
        check("midrst busy", 32'(bus.busy), 32'h0);
        check("midrst in_ready", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst done", 32'(bus.done), 32'h0);
        check("postrst out_en", 32'(bus.out_en), 32'h0);

        // DIM=1 instance: no flush, done right after each last accept
        step1(1'b1, 8'h7F, 1'b1);
        check("d1 a out", 32'(bus1.out_data), 32'h7F);
        check("d1 a done", 32'(bus1.done), 32'h1);
        check("d1 a en", 32'(bus1.out_en), 32'h1);
        check("d1 a busy", 32'(bus1.busy), 32'h0);
        step1(1'b1, 8'h80, 1'b1);
        check("d1 b out", 32'(bus1.out_data), 32'h80);
        check("d1 b done", 32'(bus1.done), 32'h1);
        step1(1'b1, 8'h11, 1'b0);
        check("d1 c out", 32'(bus1.out_data), 32'h11);
        check("d1 c done", 32'(bus1.done), 32'h0);
        check("d1 c busy", 32'(bus1.busy), 32'h1);
        step1(1'b0, 8'h00, 1'b0);
        check("d1 gap out", 32'(bus1.out_data), BUB ? 32'h00 : 32'h11);
        check("d1 gap en", 32'(bus1.out_en), 32'(BUB));
        step1(1'b1, 8'h22, 1'b1);
        check("d1 d out", 32'(bus1.out_data), 32'h22);
        check("d1 d done", 32'(bus1.done), 32'h1);
        check("d1 d busy", 32'(bus1.busy), 32'h0);
        step1(1'b0, 8'h00, 1'b0);
        check("d1 idle en", 32'(bus1.out_en), 32'h0);
        check("d1 idle done", 32'(bus1.done), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tpu_skew_feeder.md
Name: tpu_skew_feeder

Overview:
- Operand feeder for one edge of the systolic MAC array; one instance each for the A edge and the B edge.
- Accepts one DIM-wide operand vector per cycle on a valid/ready handshake.
- Emits the vector diagonally skewed: lane i is delayed i cycles relative to lane 0.
- Drives out_en, which connects directly to the array's en, so every MAC advances only when fresh skewed data is presented. After the last vector it flushes zeros until lane DIM-1 has presented that vector.

Parameters:
- BITS_AB, 8, operand width per lane (signed).
- DIM, 8, number of lanes (array rows or columns); legal range 1..64.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  vector available.
- in_ready  out  1  feeder can accept a vector this cycle.
- in_data  in  DIM*BITS_AB  operand vector; lane i = bits [i*BITS_AB +: BITS_AB].
- in_last  in  1  qualifies the accepted vector as the final one of the operation.
- out_data  out  DIM*BITS_AB  skewed operand lanes to the array edge, same packing.
- out_en  out  1  array enable; high exactly in cycles where out_data holds newly shifted data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse in the cycle lane DIM-1 presents the last vector.

Behaviour:
- Reset (async, rst_n=0): all skew registers 0; out_data=0, out_en=0, done=0, busy=0, state IDLE, flush counter 0. Reset mid-operation abandons the operation immediately; no done pulse is issued.
- Skew structure:
  - Lane i is a shift chain of i+1 registers.
  - out_data lane i is the tail of lane i's chain.
  - On a shift edge, each chain head loads its in_data lane if a vector is accepted this edge, otherwise 0.
  - All lanes shift together; no shift means all registers hold.
- Latency: vector accepted at edge k presents lane j in the cycle after edge k+j, provided every edge from k through k+j is a shift edge.
- Accept condition: in_valid && in_ready.
- out_en is a registered output, set to 1 after a shift edge and 0 after a non-shift edge.
- FSM (IDLE, STREAM, FLUSH):
  - IDLE: in_ready=1. Accept: shift. If in_last && DIM==1, stay IDLE and set done next cycle. If in_last && DIM>1, go to FLUSH with cnt=DIM-2. Otherwise go to STREAM. No accept: no shift.
  - STREAM: in_ready=1. Accept: shift. If in_last, go to FLUSH with cnt=DIM-2, or to IDLE with done if DIM==1. No accept: stall (no shift, out_en=0 next cycle; see optional feature).
  - FLUSH: in_ready=0. Every edge shifts a zero vector. If cnt==0, go to IDLE and set done=1 next cycle; else cnt--.
- done is registered: high for exactly one cycle, coincident with out_en=1 and the final lane-DIM-1 value.
- A new vector may be accepted in the IDLE cycle where done=1 (back-to-back operations). Chain contents left over from the previous flush are zeros ahead of new data.
- in_last is ignored unless the vector is accepted. in_data is not sampled when in_ready=0.
- Flush counter width: clog2(DIM) bits, minimum 1.

Optional Feature:
- Macro TPU_FEEDER_BUBBLE_EN.
- Defined: in STREAM with no accept, shift a zero vector and set out_en=1, so the array never stalls and bubbles enter as zero products.
- Undefined: stall behaviour as above (hold, out_en=0).
- IDLE and FLUSH behaviour are identical in both builds.

Test Plan:
- Reset/idle (DIM=4, BITS_AB=8): rst_n low mid-sim -> out_data=0, out_en=0, busy=0, in_ready=1 asynchronously, before the next clk edge.
- Stream with no gaps: vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} (last) on consecutive edges.
  - Cycle after edge 0: lanes {1,0,0,0}.
  - Edge 1: {5,2,0,0}. Edge 2: {9,6,3,0}. Edge 3: {0,10,7,4}. Edge 4: {0,0,11,8}. Edge 5: {0,0,0,12} with done=1.
  - out_en=1 for cycles after edges 0..5, then 0.
- Stall (macro undefined): drop in_valid for 2 cycles after the first accept -> out_data holds {1,0,0,0} and out_en=0 for those 2 cycles; the stream resumes identically afterwards.
- Bubble (macro defined): same stimulus -> two zero vectors shift in with out_en=1; lane 1 shows 2 one cycle later, then 0, 0.
- Flush and back-to-back: busy=1 and in_ready=0 during DIM-1=3 flush cycles. Assert in_valid in the done cycle -> that vector is accepted, busy stays 1, and the new lane 0 appears the next cycle.
- DIM=1 build: single vector with in_last -> out_data=value and done=1 in the next cycle, and no FLUSH state is entered.
